match_ctrl: RTL and testbench
=============================

# match_ctrl

Match sequencer for the two-player button-race game. It drives the game's OPTION input to start and restart rounds, and watches the game SCREEN code and both players' press counts. From these it judges each round, keeps a best-of-N tally, and declares a match winner. It sits between the mode/menu logic and the game core, replacing the manual "press all four buttons" restart between rounds.

## Interface

Parameters:
- WIN_ROUNDS, 2: decisive rounds a player needs to win the match (2 gives best of 3). Legal range 1–3.
- PAUSE_CYCLES, 2000: length of the inter-round pause in CLK cycles (2 s at 1 kHz).
- RUN_TIMEOUT, 60000: maximum CLK cycles in RUN before the round is aborted as a draw.

Ports:
- CLK, in, 1: system clock. There is one clock only.
- RESET, in, 1: synchronous, active-high reset.
- START, in, 1: level button. Rising edge detected internally.
- ABORT, in, 1: level. While high, forces IDLE.
- SCREEN, in, 3: game screen code: 001 countdown, 010 playing, 100 game over.
- P1_COUNT, in, 7: player-1 press count from the game.
- P2_COUNT, in, 7: player-2 press count from the game.
- OPTION, out, 4: game enable. 4'b0111 runs the game; 4'b0000 holds or restarts it.
- P1_WINS, out, 2: player-1 decisive rounds won.
- P2_WINS, out, 2: player-2 decisive rounds won.
- ROUND_NO, out, 3: current round number, 1-based. Saturates at 7.
- MATCH_WINNER, out, 2: 00 none, 01 P1, 10 P2.
- ROUND_DONE, out, 1: one-cycle pulse in JUDGE.
- STATE, out, 3: IDLE=0, ARM=1, RUN=2, JUDGE=3, PAUSE=4, DONE=5.

## Operation

- **Registers.** All outputs are registered.
- **Reset.** RESET gives STATE=IDLE, OPTION=0000, P1_WINS=P2_WINS=0, ROUND_NO=0, MATCH_WINNER=00, ROUND_DONE=0. The internal START edge register and all counters clear.
- **IDLE.** OPTION=0000. A START rising edge clears both tallies and MATCH_WINNER, sets ROUND_NO=1, and moves to ARM.
- **ARM.** Lasts exactly 1 cycle with OPTION=0000. This forces the game to reset to its countdown screen. Clears the seen_play flag and the run counter. Next state is RUN.
- **RUN.** OPTION=0111.
  - Whenever SCREEN==010: set seen_play and latch P1_COUNT/P2_COUNT into the score snapshot.
  - First cycle with SCREEN==100 and seen_play=1: go to JUDGE. Counts are not sampled in that cycle, because the game may already be clearing them.
  - SCREEN==100 with seen_play=0 is ignored (stale game-over from the previous round).
  - Run counter reaching RUN_TIMEOUT: go to JUDGE with a forced draw.
- **JUDGE.** Lasts 1 cycle. ROUND_DONE=1 and OPTION stays 0111.
  - Snapshot P1 > P2: P1_WINS+1. P2 > P1: P2_WINS+1. Equal counts or timeout: draw, no tally change.
  - If the incremented tally equals WIN_ROUNDS: set MATCH_WINNER and go to DONE.
  - Otherwise go to PAUSE.
- **PAUSE.** OPTION stays 0111, so the game-over screen is shown. Counts PAUSE_CYCLES cycles, then ROUND_NO+1 (saturating at 7) and go to ARM.
- **DONE.** OPTION=0111. Tallies and MATCH_WINNER are held. A START rising edge starts a new match with the same actions as the IDLE exit, going to ARM.
- **START edges elsewhere.** Ignored in ARM, RUN, JUDGE and PAUSE.
- **ABORT.** Has priority over everything except RESET. Next cycle STATE=IDLE and OPTION=0000. Tallies, ROUND_NO and MATCH_WINNER are held for display.
- **START and ABORT together.** ABORT wins. The START edge is consumed, not deferred.
- **Arithmetic.**
  - Counts are compared as unsigned 7-bit values.
  - Tallies cannot exceed WIN_ROUNDS (at most 3), so 2 bits are enough.
  - The run counter is 16 bits and the pause counter is 11 bits minimum. Widen both if the parameters require it.

## Timing

- START edge seen at cycle n: STATE=ARM and OPTION=0000 at n+1; RUN and OPTION=0111 at n+2.
- SCREEN==100 qualified at cycle m: JUDGE and ROUND_DONE=1 at m+1; tallies updated and STATE=PAUSE or DONE at m+2.
- PAUSE entered at cycle p: ARM at p+PAUSE_CYCLES, with ROUND_NO incremented in the same cycle.
- Timeout: JUDGE follows RUN_TIMEOUT cycles after RUN entry.
- ABORT at cycle a: IDLE at a+1.
- RESET mid-match: all outputs take their reset values at the next edge.
- No combinational input-to-output paths.

## Test plan

- **Reset values.** Hold RESET 3 cycles, then release → OPTION=0000, STATE=0, tallies 0, ROUND_NO=0.
- **Best-of-3 win for P1.** START pulse. Per round, SCREEN goes 001→010 with counts P1=40/P2=33, then 100 → ROUND_DONE pulses twice, P1_WINS=2, MATCH_WINNER=01, STATE=5, ROUND_NO=2. Each ARM shows exactly one OPTION=0000 cycle.
- **Draw and snapshot.**
  - Round with P1=P2=20 → tallies unchanged, ROUND_NO increments after PAUSE.
  - Round where the counts drop to 0 in the same cycle SCREEN=100 → the judgment uses the pre-100 snapshot.
- **Stale game-over.** SCREEN held at 100 through ARM and into RUN, without 010 → no JUDGE occurs.
- **Timeout.** RUN_TIMEOUT=50, SCREEN stuck at 010 → JUDGE 50 cycles after RUN entry, draw, no tally change.
- **ABORT handling.**
  - ABORT mid-PAUSE → IDLE next cycle, OPTION=0000, tallies held.
  - START and ABORT in the same cycle → stays IDLE.
  - START in DONE → tallies cleared, ROUND_NO=1, ARM.

Source files
------------

// File: rtl/match_ctrl.sv
// Match sequencer for the two-player button race: restarts rounds through OPTION,
// judges each round from the score snapshot, and keeps a best-of-N tally.
module match_ctrl #(
  parameter int WIN_ROUNDS   = 2,
  parameter int PAUSE_CYCLES = 2000,
  parameter int RUN_TIMEOUT  = 60000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ABORT,
  input  logic [2:0] SCREEN,
  input  logic [6:0] P1_COUNT,
  input  logic [6:0] P2_COUNT,
  output logic [3:0] OPTION,
  output logic [1:0] P1_WINS,
  output logic [1:0] P2_WINS,
  output logic [2:0] ROUND_NO,
  output logic [1:0] MATCH_WINNER,
  output logic       ROUND_DONE,
  output logic [2:0] STATE
);

  localparam int RUN_W   = ($clog2(RUN_TIMEOUT + 1) > 16) ? $clog2(RUN_TIMEOUT + 1) : 16;
  localparam int PAUSE_W = ($clog2(PAUSE_CYCLES + 1) > 11) ? $clog2(PAUSE_CYCLES + 1) : 11;
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_TIMEOUT - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [1:0]         WIN_TALLY  = 2'(WIN_ROUNDS);
  localparam logic [3:0]         OPT_RUN    = 4'b0111;
  localparam logic [3:0]         OPT_HOLD   = 4'b0000;
  localparam logic [2:0]         SCR_PLAY   = 3'b010;
  localparam logic [2:0]         SCR_OVER   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_JUDGE = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic                 seen_play_q, seen_play_d;
  logic                 timed_out_q, timed_out_d;
  logic [6:0]           snap_p1_q, snap_p1_d;
  logic [6:0]           snap_p2_q, snap_p2_d;
  logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
  logic [PAUSE_W-1:0]   pause_cnt_q, pause_cnt_d;
  logic [1:0]           p1_wins_q, p1_wins_d;
  logic [1:0]           p2_wins_q, p2_wins_d;
  logic [2:0]           round_no_q, round_no_d;
  logic [1:0]           winner_q, winner_d;
  logic                 round_done_q, round_done_d;
  logic [3:0]           option_q, option_d;
  logic                 start_edge;

  assign start_edge = START & ~start_q;

  always_comb begin
    state_d      = state_q;
    seen_play_d  = seen_play_q;
    timed_out_d  = timed_out_q;
    snap_p1_d    = snap_p1_q;
    snap_p2_d    = snap_p2_q;
    run_cnt_d    = run_cnt_q;
    pause_cnt_d  = pause_cnt_q;
    p1_wins_d    = p1_wins_q;
    p2_wins_d    = p2_wins_q;
    round_no_d   = round_no_q;
    winner_d     = winner_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          p1_wins_d  = 2'd0;
          p2_wins_d  = 2'd0;
          winner_d   = 2'b00;
          round_no_d = 3'd1;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        seen_play_d = 1'b0;
        timed_out_d = 1'b0;
        run_cnt_d   = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (SCREEN == SCR_PLAY) begin
          seen_play_d = 1'b1;
          snap_p1_d   = P1_COUNT;
          snap_p2_d   = P2_COUNT;
        end
        // A game-over screen only counts once this round has actually been played.
        if (SCREEN == SCR_OVER && seen_play_q) begin
          state_d = S_JUDGE;
        end else if (run_cnt_q == RUN_LAST) begin
          timed_out_d = 1'b1;
          state_d     = S_JUDGE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      S_JUDGE: begin
        pause_cnt_d = '0;
        state_d     = S_PAUSE;
        if (!timed_out_q && snap_p1_q > snap_p2_q) begin
          p1_wins_d = p1_wins_q + 2'd1;
          if (p1_wins_d == WIN_TALLY) begin
            winner_d = 2'b01;
            state_d  = S_DONE;
          end
        end else if (!timed_out_q && snap_p2_q > snap_p1_q) begin
          p2_wins_d = p2_wins_q + 2'd1;
          if (p2_wins_d == WIN_TALLY) begin
            winner_d = 2'b10;
            state_d  = S_DONE;
          end
        end
      end
      S_PAUSE: begin
        if (pause_cnt_q == PAUSE_LAST) begin
          round_no_d = (round_no_q == 3'd7) ? 3'd7 : round_no_q + 3'd1;
          state_d    = S_ARM;
        end else begin
          pause_cnt_d = pause_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops back to IDLE but leaves the scoreboard on display.
    if (ABORT) begin
      state_d    = S_IDLE;
      p1_wins_d  = p1_wins_q;
      p2_wins_d  = p2_wins_q;
      round_no_d = round_no_q;
      winner_d   = winner_q;
    end

    round_done_d = (state_d == S_JUDGE);
    option_d     = (state_d == S_IDLE || state_d == S_ARM) ? OPT_HOLD : OPT_RUN;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      seen_play_q  <= 1'b0;
      timed_out_q  <= 1'b0;
      snap_p1_q    <= 7'd0;
      snap_p2_q    <= 7'd0;
      run_cnt_q    <= '0;
      pause_cnt_q  <= '0;
      p1_wins_q    <= 2'd0;
      p2_wins_q    <= 2'd0;
      round_no_q   <= 3'd0;
      winner_q     <= 2'b00;
      round_done_q <= 1'b0;
      option_q     <= OPT_HOLD;
    end else begin
      state_q      <= state_d;
      start_q      <= START;
      seen_play_q  <= seen_play_d;
      timed_out_q  <= timed_out_d;
      snap_p1_q    <= snap_p1_d;
      snap_p2_q    <= snap_p2_d;
      run_cnt_q    <= run_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      p1_wins_q    <= p1_wins_d;
      p2_wins_q    <= p2_wins_d;
      round_no_q   <= round_no_d;
      winner_q     <= winner_d;
      round_done_q <= round_done_d;
      option_q     <= option_d;
    end
  end

  assign OPTION       = option_q;
  assign P1_WINS      = p1_wins_q;
  assign P2_WINS      = p2_wins_q;
  assign ROUND_NO     = round_no_q;
  assign MATCH_WINNER = winner_q;
  assign ROUND_DONE   = round_done_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: scenario tasks plus randomized matches scored by a round-level model.
module tb_match_ctrl;

  localparam int WIN   = 2;
  localparam int PAUSE = 20;
  localparam int TMO   = 50;

  logic       CLK;
  logic       RESET, START, ABORT;
  logic [2:0] SCREEN;
  logic [6:0] P1_COUNT, P2_COUNT;
  logic [3:0] OPTION;
  logic [1:0] P1_WINS, P2_WINS, MATCH_WINNER;
  logic [2:0] ROUND_NO, STATE;
  logic       ROUND_DONE;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_pulses = 0;
  int exp_p1, exp_p2, exp_win, exp_round;

  match_ctrl #(.WIN_ROUNDS(WIN), .PAUSE_CYCLES(PAUSE), .RUN_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .SCREEN(SCREEN),
    .P1_COUNT(P1_COUNT), .P2_COUNT(P2_COUNT), .OPTION(OPTION), .P1_WINS(P1_WINS),
    .P2_WINS(P2_WINS), .ROUND_NO(ROUND_NO), .MATCH_WINNER(MATCH_WINNER),
    .ROUND_DONE(ROUND_DONE), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (ROUND_DONE === 1'b1) rd_pulses++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Round-level scoring model: a decisive round adds one to the winner's tally.
  function automatic bit model_judge(input int a, input int b, input bit timed_out);
    bit done;
    done = 1'b0;
    if (!timed_out && a > b) begin
      exp_p1++;
      if (exp_p1 == WIN) begin exp_win = 1; done = 1'b1; end
    end else if (!timed_out && b > a) begin
      exp_p2++;
      if (exp_p2 == WIN) begin exp_win = 2; done = 1'b1; end
    end
    return done;
  endfunction

  task automatic start_match();
    START = 1'b1;
    tick();
    exp_p1 = 0; exp_p2 = 0; exp_win = 0; exp_round = 1;
    n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL start_arm_state: got %0d want 1", STATE); end
    n_checks++; if (OPTION !== 4'b0000) begin n_fail++; $display("FAIL start_arm_option: got %b want 0000", OPTION); end
    n_checks++; if (P1_WINS !== 2'(exp_p1) || P2_WINS !== 2'(exp_p2) || MATCH_WINNER !== 2'(exp_win)) begin n_fail++; $display("FAIL start_clear: got p1=%0d p2=%0d win=%0d want 0 0 0", P1_WINS, P2_WINS, MATCH_WINNER); end
    n_checks++; if (ROUND_NO !== 3'(exp_round)) begin n_fail++; $display("FAIL start_round: got %0d want %0d", ROUND_NO, exp_round); end
    START = 1'b0;
    tick();
    n_checks++; if (STATE !== 3'd2 || OPTION !== 4'b0111) begin n_fail++; $display("FAIL start_run: got state=%0d opt=%b want 2 0111", STATE, OPTION); end
  endtask

  task automatic play_round(input int a, input int b, input bit zero_at_over, input bit stop_in_pause, output bit done);
    int cnt;
    int want_state;
    SCREEN = 3'b001; P1_COUNT = 7'd0; P2_COUNT = 7'd0;
    tick(); tick();
    SCREEN = 3'b010; P1_COUNT = 7'(a); P2_COUNT = 7'(b);
    tick(); tick(); tick();
    SCREEN = 3'b100;
    if (zero_at_over) begin P1_COUNT = 7'd0; P2_COUNT = 7'd0; end
    tick();
    n_checks++; if (STATE !== 3'd3 || ROUND_DONE !== 1'b1 || OPTION !== 4'b0111) begin n_fail++; $display("FAIL judge_entry: got state=%0d rd=%b opt=%b want 3 1 0111", STATE, ROUND_DONE, OPTION); end
    n_checks++; if (ROUND_NO !== 3'(exp_round)) begin n_fail++; $display("FAIL judge_round_no: got %0d want %0d", ROUND_NO, exp_round); end
    done = model_judge(a, b, 1'b0);
    want_state = done ? 5 : 4;
    tick();
    n_checks++; if (STATE !== 3'(want_state) || ROUND_DONE !== 1'b0) begin n_fail++; $display("FAIL judge_exit: got state=%0d rd=%b want %0d 0", STATE, ROUND_DONE, want_state); end
    n_checks++; if (P1_WINS !== 2'(exp_p1) || P2_WINS !== 2'(exp_p2) || MATCH_WINNER !== 2'(exp_win)) begin n_fail++; $display("FAIL tally a=%0d b=%0d: got p1=%0d p2=%0d win=%0d want %0d %0d %0d", a, b, P1_WINS, P2_WINS, MATCH_WINNER, exp_p1, exp_p2, exp_win); end
    if (!done && !stop_in_pause) begin
      cnt = 0;
      do begin tick(); cnt++; end while (STATE == 3'd4 && cnt < PAUSE + 10);
      exp_round = (exp_round < 7) ? exp_round + 1 : 7;
      n_checks++; if (cnt != PAUSE || STATE !== 3'd1 || OPTION !== 4'b0000) begin n_fail++; $display("FAIL pause_len: got %0d cycles state=%0d opt=%b want %0d 1 0000", cnt, STATE, OPTION, PAUSE); end
      n_checks++; if (ROUND_NO !== 3'(exp_round)) begin n_fail++; $display("FAIL round_inc: got %0d want %0d", ROUND_NO, exp_round); end
      tick();
      n_checks++; if (STATE !== 3'd2 || OPTION !== 4'b0111) begin n_fail++; $display("FAIL arm_one_cycle: got state=%0d opt=%b want 2 0111", STATE, OPTION); end
    end
  endtask

  task automatic go_idle();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    n_checks++; if (STATE !== 3'd0 || OPTION !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: got state=%0d opt=%b want 0 0000", STATE, OPTION); end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; SCREEN = 3'b000; P1_COUNT = 7'd0; P2_COUNT = 7'd0;
    tick(); tick(); tick();
    RESET = 1'b0;
    n_checks++; if (STATE !== 3'd0 || OPTION !== 4'b0000 || ROUND_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got state=%0d opt=%b rd=%b want 0 0000 0", STATE, OPTION, ROUND_DONE); end
    n_checks++; if (P1_WINS !== 2'd0 || P2_WINS !== 2'd0 || ROUND_NO !== 3'd0 || MATCH_WINNER !== 2'd0) begin n_fail++; $display("FAIL reset_score: got p1=%0d p2=%0d rn=%0d win=%0d want all 0", P1_WINS, P2_WINS, ROUND_NO, MATCH_WINNER); end
    tick();
    n_checks++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL reset_stay_idle: got %0d want 0", STATE); end
  endtask

  task automatic test_best_of_3();
    bit done;
    int rd0;
    rd0 = rd_pulses;
    start_match();
    play_round(40, 33, 1'b0, 1'b0, done);
    play_round(40, 33, 1'b0, 1'b0, done);
    n_checks++; if (STATE !== 3'd5 || MATCH_WINNER !== 2'b01 || P1_WINS !== 2'd2 || ROUND_NO !== 3'd2) begin n_fail++; $display("FAIL bo3_final: got state=%0d win=%0d p1=%0d rn=%0d want 5 1 2 2", STATE, MATCH_WINNER, P1_WINS, ROUND_NO); end
    n_checks++; if (rd_pulses - rd0 != 2) begin n_fail++; $display("FAIL bo3_pulses: got %0d want 2", rd_pulses - rd0); end
    tick(); tick();
    n_checks++; if (STATE !== 3'd5 || OPTION !== 4'b0111 || P1_WINS !== 2'd2) begin n_fail++; $display("FAIL done_hold: got state=%0d opt=%b p1=%0d want 5 0111 2", STATE, OPTION, P1_WINS); end
  endtask

  task automatic test_draw_snapshot();
    bit done;
    int v;
    start_match();
    for (int i = 0; i < 7; i++) begin
      v = int'($urandom_range(0, 127));
      play_round(v, v, 1'b0, 1'b0, done);
    end
    play_round(10, 30, 1'b1, 1'b1, done);
  endtask

  task automatic test_abort_pause();
    tick(); tick(); tick();
    n_checks++; if (STATE !== 3'd4) begin n_fail++; $display("FAIL in_pause: got %0d want 4", STATE); end
    go_idle();
    n_checks++; if (P1_WINS !== 2'(exp_p1) || P2_WINS !== 2'(exp_p2) || ROUND_NO !== 3'(exp_round) || MATCH_WINNER !== 2'(exp_win)) begin n_fail++; $display("FAIL abort_hold: got p1=%0d p2=%0d rn=%0d win=%0d want %0d %0d %0d %0d", P1_WINS, P2_WINS, ROUND_NO, MATCH_WINNER, exp_p1, exp_p2, exp_round, exp_win); end
  endtask

  task automatic test_start_abort();
    START = 1'b1; ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    n_checks++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL start_abort_same: got %0d want 0", STATE); end
    tick();
    n_checks++; if (STATE !== 3'd0 || P2_WINS !== 2'(exp_p2)) begin n_fail++; $display("FAIL start_consumed: got state=%0d p2=%0d want 0 %0d", STATE, P2_WINS, exp_p2); end
    START = 1'b0;
    tick();
  endtask

  task automatic test_stale();
    int judges;
    SCREEN = 3'b100;
    start_match();
    judges = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ROUND_DONE === 1'b1 || STATE === 3'd3) judges++;
    end
    n_checks++; if (judges != 0 || STATE !== 3'd2) begin n_fail++; $display("FAIL stale_over: got judges=%0d state=%0d want 0 2", judges, STATE); end
    go_idle();
  endtask

  task automatic test_timeout();
    int cnt;
    bit done;
    start_match();
    SCREEN = 3'b010; P1_COUNT = 7'd90; P2_COUNT = 7'd10;
    cnt = 0;
    do begin tick(); cnt++; end while (STATE != 3'd3 && cnt < 4 * TMO);
    n_checks++; if (cnt != TMO || ROUND_DONE !== 1'b1) begin n_fail++; $display("FAIL timeout_len: got %0d cycles rd=%b want %0d 1", cnt, ROUND_DONE, TMO); end
    done = model_judge(90, 10, 1'b1);
    tick();
    n_checks++; if (STATE !== (done ? 3'd5 : 3'd4) || P1_WINS !== 2'(exp_p1) || P2_WINS !== 2'(exp_p2)) begin n_fail++; $display("FAIL timeout_draw: got state=%0d p1=%0d p2=%0d want 4 %0d %0d", STATE, P1_WINS, P2_WINS, exp_p1, exp_p2); end
    go_idle();
  endtask

  task automatic test_random();
    bit done;
    int a, b, r;
    for (int m = 0; m < 4; m++) begin
      start_match();
      done = 1'b0;
      r = 0;
      while (!done && r < 12) begin
        a = int'($urandom_range(0, 127));
        b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 127));
        play_round(a, b, 1'($urandom_range(0, 1)), 1'b0, done);
        r++;
      end
      if (!done) go_idle();
    end
  endtask

  task automatic test_reset_mid();
    start_match();
    SCREEN = 3'b010; P1_COUNT = 7'd5; P2_COUNT = 7'd3;
    tick(); tick();
    RESET = 1'b1;
    tick();
    n_checks++; if (STATE !== 3'd0 || OPTION !== 4'b0000 || ROUND_NO !== 3'd0 || P1_WINS !== 2'd0 || P2_WINS !== 2'd0 || MATCH_WINNER !== 2'd0 || ROUND_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got state=%0d opt=%b rn=%0d want 0 0000 0", STATE, OPTION, ROUND_NO); end
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_best_of_3();
    test_draw_snapshot();
    test_abort_pause();
    test_start_abort();
    test_stale();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
